// File: rtl/fd_pipe_stage.sv
// Fetch->Decode pipeline register with valid bit, stall hold, flush bubble and one-entry skid buffer.
// Latency: 1 cycle from an accepted fetch transfer to PCD/InstrD/PCPlus4D (2 when it passes through the skid).
// Backpressure: ReadyF = !skid_valid, registered; a stall parks at most one accepted instruction in the skid.
// Optional build macro FD_PERF_CNT_EN adds saturating StallCnt/FlushCnt/BubbleCnt counters (CNT_WIDTH wide).
module fd_pipe_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
`ifdef FD_PERF_CNT_EN
    ,
    parameter int                    CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] InstrF,
    input  logic [DATA_WIDTH-1:0] PCPlus4F,
    input  logic                  ValidF,
    output logic                  ReadyF,
    input  logic                  StallD,
    input  logic                  FlushD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
`ifdef FD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  StallCnt,
    output logic [CNT_WIDTH-1:0]  FlushCnt,
    output logic [CNT_WIDTH-1:0]  BubbleCnt
`endif
);

    // Main (decode-facing) register
    logic [DATA_WIDTH-1:0] pc_q,    pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pcp4_q,  pcp4_d;
    logic                  valid_q, valid_d;

    // Skid entry: always older than anything fetch offers while it is full
    logic [DATA_WIDTH-1:0] skid_pc_q,    skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pcp4_q,  skid_pcp4_d;
    logic                  skid_vld_q,   skid_vld_d;

    logic transfer;
    logic load_bubble;

    // Ready depends only on registered skid state, never on StallD/FlushD
    assign ReadyF   = !skid_vld_q;
    assign transfer = ValidF && !skid_vld_q;

    assign PCD      = pc_q;
    assign InstrD   = instr_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

    // Next-state selection: flush beats stall beats skid drain beats fresh load
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcp4_d       = pcp4_q;
        valid_d      = valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pcp4_d  = skid_pcp4_q;
        skid_vld_d   = skid_vld_q;
        load_bubble  = 1'b0;

        if (FlushD) begin
            // Kill decode and skid; any same-cycle transfer is dropped, PCs hold
            valid_d     = 1'b0;
            instr_d     = NOP_INSTR;
            skid_vld_d  = 1'b0;
            load_bubble = 1'b1;
        end else if (StallD) begin
            // Decode holds; an accepted instruction parks in the (empty) skid
            if (transfer) begin
                skid_pc_d    = PCF;
                skid_instr_d = InstrF;
                skid_pcp4_d  = PCPlus4F;
                skid_vld_d   = 1'b1;
            end
        end else if (skid_vld_q) begin
            // Drain the older skid entry first; ReadyF=0 so no new transfer
            pc_d       = skid_pc_q;
            instr_d    = skid_instr_q;
            pcp4_d     = skid_pcp4_q;
            valid_d    = 1'b1;
            skid_vld_d = 1'b0;
        end else if (transfer) begin
            pc_d    = PCF;
            instr_d = InstrF;
            pcp4_d  = PCPlus4F;
            valid_d = 1'b1;
        end else begin
            // Nothing to pass on: bubble with PCs held
            valid_d     = 1'b0;
            instr_d     = NOP_INSTR;
            load_bubble = 1'b1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            instr_q      <= NOP_INSTR;
            pcp4_q       <= '0;
            valid_q      <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_pcp4_q  <= '0;
            skid_vld_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp4_q  <= skid_pcp4_d;
            skid_vld_q   <= skid_vld_d;
        end
    end

`ifdef FD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;
    logic [CNT_WIDTH-1:0] bubble_cnt_q;

    assign StallCnt  = stall_cnt_q;
    assign FlushCnt  = flush_cnt_q;
    assign BubbleCnt = bubble_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (StallD && !FlushD && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            if (FlushD && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            if (load_bubble && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fd_pipe_stage.sv
// Directed self-checking bench for fd_pipe_stage; counter scenarios run when FD_PERF_CNT_EN is defined.
module tb_fd_pipe_stage;

    localparam int          DW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FD_PERF_CNT_EN
    localparam int          CW  = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] PCF, InstrF, PCPlus4F;
    logic          ValidF, ReadyF, StallD, FlushD;
    logic [DW-1:0] PCD, InstrD, PCPlus4D;
    logic          ValidD;
`ifdef FD_PERF_CNT_EN
    logic [CW-1:0] StallCnt, FlushCnt, BubbleCnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fd_pipe_stage #(
        .DATA_WIDTH(DW),
        .NOP_INSTR (NOP)
`ifdef FD_PERF_CNT_EN
        ,
        .CNT_WIDTH (CW)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PCF      (PCF),
        .InstrF   (InstrF),
        .PCPlus4F (PCPlus4F),
        .ValidF   (ValidF),
        .ReadyF   (ReadyF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .PCD      (PCD),
        .InstrD   (InstrD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
`ifdef FD_PERF_CNT_EN
        ,
        .StallCnt (StallCnt),
        .FlushCnt (FlushCnt),
        .BubbleCnt(BubbleCnt)
`endif
    );

    // Instruction word encodes its PC so ordering mistakes are visible on InstrD
    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic offer(input logic v, input logic [31:0] pc);
        ValidF   = v;
        PCF      = pc;
        InstrF   = ins(pc);
        PCPlus4F = pc + 32'd4;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; StallD = 1'b0; FlushD = 1'b0;
        offer(1'b0, 32'h0);
        repeat (2) cyc();
        total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ValidD); end
        total++; if (ReadyF !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", ReadyF); end
        total++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h/%h want=0/0", PCD, PCPlus4D); end
        total++; if (InstrD !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", InstrD, NOP); end
        #2 rst = 1'b0;
        cyc();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'(i * 4));
            cyc();
            total++;
            if (PCD !== 32'(i * 4) || InstrD !== ins(32'(i * 4)) || PCPlus4D !== 32'(i * 4 + 4) || ValidD !== 1'b1 || ReadyF !== 1'b1) begin
                bad++;
                $display("FAIL stream_%0d got pc=%h ins=%h p4=%h v=%0b r=%0b want pc=%h v=1 r=1",
                         i, PCD, InstrD, PCPlus4D, ValidD, ReadyF, 32'(i * 4));
            end
        end
    endtask

    // Decode holds 0x0C; 0x10 is accepted during a one-cycle stall
    task automatic test_single_stall();
        StallD = 1'b1; offer(1'b1, 32'h10);
        cyc();
        total++; if (PCD !== 32'h0C || ReadyF !== 1'b0) begin bad++; $display("FAIL stall1_hold got pc=%h r=%0b want pc=0c r=0", PCD, ReadyF); end
        StallD = 1'b0; offer(1'b1, 32'h14);
        cyc();
        total++; if (PCD !== 32'h10 || InstrD !== ins(32'h10) || ValidD !== 1'b1 || ReadyF !== 1'b1) begin bad++; $display("FAIL stall1_drain got pc=%h ins=%h v=%0b r=%0b want pc=10 v=1 r=1", PCD, InstrD, ValidD, ReadyF); end
        cyc();
        total++; if (PCD !== 32'h14 || InstrD !== ins(32'h14) || ValidD !== 1'b1) begin bad++; $display("FAIL stall1_next got pc=%h ins=%h v=%0b want pc=14 v=1", PCD, InstrD, ValidD); end
    endtask

    task automatic test_long_stall();
        StallD = 1'b1; offer(1'b1, 32'h18);
        cyc();
        offer(1'b1, 32'h1C);
        for (int i = 1; i < 4; i++) begin
            total++;
            if (PCD !== 32'h14 || ReadyF !== 1'b0 || ValidD !== 1'b1) begin
                bad++; $display("FAIL long_stall_%0d got pc=%h r=%0b v=%0b want pc=14 r=0 v=1", i, PCD, ReadyF, ValidD);
            end
            cyc();
        end
        total++; if (PCD !== 32'h14 || ReadyF !== 1'b0) begin bad++; $display("FAIL long_stall_4 got pc=%h r=%0b want pc=14 r=0", PCD, ReadyF); end
        StallD = 1'b0;
        cyc();
        total++; if (PCD !== 32'h18 || InstrD !== ins(32'h18) || ReadyF !== 1'b1) begin bad++; $display("FAIL long_release got pc=%h ins=%h r=%0b want pc=18 r=1", PCD, InstrD, ReadyF); end
        cyc();
        total++; if (PCD !== 32'h1C || InstrD !== ins(32'h1C) || ValidD !== 1'b1) begin bad++; $display("FAIL long_after got pc=%h ins=%h v=%0b want pc=1c v=1", PCD, InstrD, ValidD); end
    endtask

    task automatic test_flush();
        StallD = 1'b1; offer(1'b1, 32'h20);
        cyc();
        total++; if (ReadyF !== 1'b0) begin bad++; $display("FAIL flush_skidfull got r=%0b want 0", ReadyF); end
        FlushD = 1'b1; offer(1'b1, 32'h24);
        cyc();
        total++; if (ValidD !== 1'b0 || InstrD !== NOP || ReadyF !== 1'b1 || PCD !== 32'h1C) begin bad++; $display("FAIL flush_full got v=%0b ins=%h r=%0b pc=%h want v=0 ins=%h r=1 pc=1c", ValidD, InstrD, ReadyF, PCD, NOP); end
        FlushD = 1'b0; StallD = 1'b0; offer(1'b0, 32'h24);
        cyc();
        total++; if (ValidD !== 1'b0 || PCD !== 32'h1C || InstrD !== NOP) begin bad++; $display("FAIL flush_bubble got v=%0b pc=%h ins=%h want v=0 pc=1c", ValidD, PCD, InstrD); end
        offer(1'b1, 32'h24);
        cyc();
        total++; if (ValidD !== 1'b1 || PCD !== 32'h24 || PCPlus4D !== 32'h28) begin bad++; $display("FAIL flush_resume got v=%0b pc=%h p4=%h want v=1 pc=24 p4=28", ValidD, PCD, PCPlus4D); end
        // Transfer accepted during a flush must be discarded
        FlushD = 1'b1; offer(1'b1, 32'h28);
        cyc();
        total++; if (ValidD !== 1'b0 || PCD !== 32'h24 || ReadyF !== 1'b1) begin bad++; $display("FAIL flush_drop got v=%0b pc=%h r=%0b want v=0 pc=24 r=1", ValidD, PCD, ReadyF); end
        FlushD = 1'b0; offer(1'b0, 32'h28);
        cyc();
        total++; if (ValidD !== 1'b0 || PCD !== 32'h24) begin bad++; $display("FAIL flush_nodup got v=%0b pc=%h want v=0 pc=24", ValidD, PCD); end
    endtask

    task automatic test_async_reset();
        offer(1'b1, 32'h2C);
        cyc();
        StallD = 1'b1; offer(1'b1, 32'h30);
        cyc();
        #2 rst = 1'b1;
        #1;
        total++; if (ValidD !== 1'b0 || ReadyF !== 1'b1 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || InstrD !== NOP) begin bad++; $display("FAIL async_rst got v=%0b r=%0b pc=%h p4=%h ins=%h want 0/1/0/0/%h", ValidD, ReadyF, PCD, PCPlus4D, InstrD, NOP); end
`ifdef FD_PERF_CNT_EN
        total++; if (StallCnt !== '0 || FlushCnt !== '0 || BubbleCnt !== '0) begin bad++; $display("FAIL async_rst_cnt got %0d/%0d/%0d want 0/0/0", StallCnt, FlushCnt, BubbleCnt); end
`endif
        #1 rst = 1'b0;
        StallD = 1'b0; offer(1'b1, 32'h40);
        cyc();
        total++; if (PCD !== 32'h40 || ValidD !== 1'b1 || ReadyF !== 1'b1) begin bad++; $display("FAIL post_rst got pc=%h v=%0b r=%0b want pc=40 v=1 r=1", PCD, ValidD, ReadyF); end
    endtask

`ifdef FD_PERF_CNT_EN
    task automatic test_counters();
        #2 rst = 1'b1; #2 rst = 1'b0;
        StallD = 1'b1; FlushD = 1'b0; offer(1'b0, 32'h0);
        repeat (20) cyc();
        total++; if (StallCnt !== 4'd15) begin bad++; $display("FAIL stall_cnt_sat got=%0d want=15", StallCnt); end
        total++; if (FlushCnt !== 4'd0 || BubbleCnt !== 4'd0) begin bad++; $display("FAIL stall_only_cnt got f=%0d b=%0d want 0/0", FlushCnt, BubbleCnt); end
        #2 rst = 1'b1; #2 rst = 1'b0;
        StallD = 1'b0; FlushD = 1'b1; offer(1'b1, 32'h50);
        repeat (2) cyc();
        FlushD = 1'b0; StallD = 1'b1;
        cyc();
        total++; if (FlushCnt !== 4'd2) begin bad++; $display("FAIL flush_cnt got=%0d want=2", FlushCnt); end
        total++; if (!(BubbleCnt >= 4'd2)) begin bad++; $display("FAIL bubble_cnt got=%0d want>=2", BubbleCnt); end
        total++; if (StallCnt !== 4'd1) begin bad++; $display("FAIL stall_cnt_flush got=%0d want=1", StallCnt); end
        StallD = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_single_stall();
        test_long_stall();
        test_flush();
        test_async_reset();
`ifdef FD_PERF_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
